pwl_host_bridge: RTL
====================

Name: pwl_host_bridge

Overview:
- Parametrised host-to-register-bus bridge; next generation of the chip-top command bridge.
- Asynchronous host strobes are synchronised and rising-edge detected, then converted into register-bus reads and writes.
- Compared with the previous generation, adds configurable data width and sync depth, a posted write queue, ordered reads, overflow status, byte-lane readback and optional address auto-increment.
- Sits between TT pins and the synth peripheral register port.

Parameters:
- DATA_W, 16: register data width; multiple of 8, range 8..32. NB = DATA_W/8.
- ADDR_W, 8: register address width; must be <= 8.
- SYNC_STAGES, 2: synchroniser flops before the edge detector; >= 2.
- WQ_DEPTH, 4: write queue entries; power of 2, >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- host_data  in  8  host byte (address or data)
- host_cmd  in  4  async strobes: [0] BYTE, [1] WRITE, [2] READ, [3] NEXT
- host_byte_sel  in  max(1,$clog2(NB))  readback byte lane
- host_rdata  out  8  selected byte of read-data register
- busy  out  1  read in progress
- wq_full  out  1  write queue full
- overflow  out  1  sticky: a write was dropped
- bus_addr  out  ADDR_W  register address
- bus_wdata  out  DATA_W  write data
- bus_we  out  1  one-cycle write strobe
- bus_re  out  1  read request, held until bus_ready
- bus_rdata  in  DATA_W  read data
- bus_ready  in  1  read data valid
- bus_stall  in  1  peripheral cannot accept a write this cycle

Behaviour:
- **Reset:** clk, synchronous active-low rst_n.
  - Sync flops reset to all-ones, so a strobe held high through reset never fires.
  - All other registers reset to 0; queue empty; state IDLE.
  - Outputs at reset: bus_we=0, bus_re=0, busy=0, overflow=0, host_rdata=0.
- **Command decode:**
  - cmd = sync_last & ~sync_prev, per bit.
  - A pin rising edge takes effect on the (SYNC_STAGES+1)th clk edge.
- **BYTE:** asm <= {host_data, asm[DATA_W-1:8]}. After NB BYTE commands, the first byte sits in the LSB.
- **WRITE:**
  - If not full: last_addr <= host_data; enqueue {host_data, asm}.
  - If full: entry dropped, overflow <= 1, last_addr unchanged.
  - Full is judged on the registered count; a pop in the same cycle does not free a slot.
- **READ:**
  - In IDLE: rd_addr <= host_data; go to RD_DRAIN.
  - While busy: ignored, with no register change.
- **Same-cycle commands:**
  - WRITE and READ together: the write is enqueued first and the read follows it.
  - BYTE together with WRITE: the enqueue uses the pre-shift asm.
- **FSM:**
  - IDLE -> RD_DRAIN on READ.
  - RD_DRAIN -> RD_ACTIVE when the queue is empty; reads never overtake posted writes.
  - RD_ACTIVE: bus_re=1 (registered), bus_addr=rd_addr.
    - On bus_ready: rdata <= bus_rdata; go to IDLE.
    - bus_re drops the cycle after bus_ready.
  - busy = (state != IDLE).
- **Write issue:**
  - bus_we = !empty && !bus_stall && state != RD_ACTIVE. This is combinational on bus_stall.
  - While asserted, bus_addr/bus_wdata present the head entry, which pops the same cycle.
  - Earliest bus_we is the cycle after enqueue.
  - While stalled, the head is held and presented continuously.
- **Quiet bus:** bus_addr/bus_wdata hold their last values when neither bus_we nor bus_re is active.
- **Pointers:** queue pointers wrap modulo WQ_DEPTH; count is $clog2(WQ_DEPTH)+1 bits.
- **Readback:** host_rdata = rdata[8*host_byte_sel +: 8], combinational. Lanes >= NB return 0.
- **Reset mid-operation:** a read in progress is aborted and the queue flushed; bus_re=0 after the reset edge.

Optional Feature:
- Macro: PWL_HOST_BRIDGE_AUTOINC_EN.
- Defined:
  - NEXT enqueues {last_addr+1 (wraps mod 2^ADDR_W), asm}, with the same full/overflow rule as WRITE.
  - On acceptance, last_addr increments.
  - A READ completion sets last_addr <= rd_addr+1, so NEXT continues after the read.
- Undefined: NEXT is ignored and last_addr is not implemented.

Decomposition:
- Package pwl_host_bridge_pkg:
  - CMD_BYTE=0, CMD_WRITE=1, CMD_READ=2, CMD_NEXT=3 bit indices.
  - State enum {IDLE, RD_DRAIN, RD_ACTIVE}.
  - Function nbytes(DATA_W).
- Sub-module pwl_host_bridge_wq: synchronous FIFO (push, pop, head, count, full, empty), parametrised by width and depth.

Test Plan:
- Reset with all host_cmd held high, then release -> no command fires; bus_we=0, busy=0, overflow=0.
- DATA_W=16: BYTE 0x34, BYTE 0x12, WRITE addr 0x05, bus_stall=0 -> bus_we pulses once, 4 cycles after the WRITE pin edge (SYNC_STAGES=2), with bus_addr=0x05, bus_wdata=0x1234.
- bus_stall=1, five WRITEs with WQ_DEPTH=4 -> wq_full=1; fifth dropped; overflow=1. Release stall -> four bus_we pulses in order on consecutive cycles, all in the cycle order of enqueue.
- Two queued writes, then READ 0x07, bus_ready 3 cycles after bus_re, bus_rdata=0xBEEF:
  - bus_re rises only after the second bus_we.
  - host_rdata with host_byte_sel=0 -> 0xEF; with host_byte_sel=1 -> 0xBE.
  - busy deasserts the cycle after bus_ready.
- With PWL_HOST_BRIDGE_AUTOINC_EN: WRITE 0xFF then NEXT twice -> writes to 0xFF, 0x00, 0x01. Without the macro, NEXT produces no bus_we.
- Assert rst_n low while in RD_ACTIVE with 2 queued writes -> next cycle bus_re=0, queue empty, busy=0; no bus_we after reset.

Source files
------------

// File: rtl/pwl_host_bridge_pkg.sv
// pwl_host_bridge_pkg: shared command bit indices, FSM state type and sizing helper for the host bridge
package pwl_host_bridge_pkg;
  localparam int CMD_BYTE  = 0;
  localparam int CMD_WRITE = 1;
  localparam int CMD_READ  = 2;
  localparam int CMD_NEXT  = 3;
  typedef enum logic [1:0] {IDLE, RD_DRAIN, RD_ACTIVE} state_t;
  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/pwl_host_bridge_wq.sv
// pwl_host_bridge_wq: synchronous FIFO holding posted register writes; pushes while full are refused
module pwl_host_bridge_wq #(
  parameter int W = 24,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rp];
  // entry storage, no reset needed since occupancy gates every read
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers wrap naturally at DEPTH; full is judged on the registered count
  always_ff @(posedge clk)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/pwl_host_bridge.sv
// pwl_host_bridge: async host strobes to register-bus reads/writes; define PWL_HOST_BRIDGE_AUTOINC_EN for NEXT auto-increment writes
module pwl_host_bridge
  import pwl_host_bridge_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WQ_DEPTH = 4,
  localparam int NB = nbytes(DATA_W),
  localparam int SW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        host_data,
  input  logic [3:0]        host_cmd,
  input  logic [SW-1:0]     host_byte_sel,
  output logic [7:0]        host_rdata,
  output logic              busy,
  output logic              wq_full,
  output logic              overflow,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  input  logic              bus_stall
);
  localparam int EW = ADDR_W + DATA_W;
  localparam int CW = $clog2(WQ_DEPTH) + 1;
  logic [3:0] sync [SYNC_STAGES];
  logic [3:0] sync_prev, cmd;
  logic [DATA_W-1:0] asm_q, rdata, wdata_q;
  logic [ADDR_W-1:0] rd_addr, addr_q, push_addr;
  logic [8*(1<<SW)-1:0] rpad;
  logic [EW-1:0] head;
  logic [CW-1:0] count;
  logic push, full, empty;
  state_t state;
  assign cmd = sync[SYNC_STAGES-1] & ~sync_prev;
`ifdef PWL_HOST_BRIDGE_AUTOINC_EN
  logic [ADDR_W-1:0] last_addr;
  assign push = cmd[CMD_WRITE] | cmd[CMD_NEXT];
  assign push_addr = cmd[CMD_WRITE] ? host_data[ADDR_W-1:0] : last_addr + 1'b1;
  // last accepted write address, or the address after a completed read
  always_ff @(posedge clk)
    if (!rst_n) last_addr <= '0;
    else if (push && !full) last_addr <= push_addr;
    else if (state == RD_ACTIVE && bus_ready) last_addr <= rd_addr + 1'b1;
`else
  logic unused_next;
  assign unused_next = cmd[CMD_NEXT];
  assign push = cmd[CMD_WRITE];
  assign push_addr = host_data[ADDR_W-1:0];
`endif
  assign bus_we = !empty && !bus_stall && state != RD_ACTIVE;
  assign bus_addr = bus_we ? head[EW-1:DATA_W] : bus_re ? rd_addr : addr_q;
  assign bus_wdata = bus_we ? head[DATA_W-1:0] : wdata_q;
  assign busy = state != IDLE;
  assign wq_full = full;
  assign rpad = (8*(1<<SW))'(rdata);
  assign host_rdata = rpad[8*host_byte_sel +: 8];
  pwl_host_bridge_wq #(.W(EW), .DEPTH(WQ_DEPTH)) u_wq (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(bus_we),
    .din({push_addr, asm_q}), .head(head), .count(count), .full(full), .empty(empty)
  );
  // strobe synchroniser; all-ones reset keeps a strobe held through reset from firing
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '1;
      sync_prev <= '1;
    end else begin
      sync[0] <= host_cmd;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      sync_prev <= sync[SYNC_STAGES-1];
    end
  // byte assembly, overflow flag, quiet-bus hold and the read FSM
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      bus_re <= 1'b0;
      asm_q <= '0;
      rd_addr <= '0;
      rdata <= '0;
      overflow <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      addr_q <= bus_addr;
      wdata_q <= bus_wdata;
      if (cmd[CMD_BYTE]) asm_q <= DATA_W'({host_data, asm_q} >> 8);
      if (push && full) overflow <= 1'b1;
      if (state == IDLE && cmd[CMD_READ]) begin
        rd_addr <= host_data[ADDR_W-1:0];
        state <= RD_DRAIN;
      end else if (state == RD_DRAIN && empty) begin
        state <= RD_ACTIVE;
        bus_re <= 1'b1;
      end else if (state == RD_ACTIVE && bus_ready) begin
        rdata <= bus_rdata;
        state <= IDLE;
        bus_re <= 1'b0;
      end
    end
endmodule
